// File: rtl/mem_access_arbiter_pkg.sv
// Shared definitions for the memory access arbiter: FSM states, stats width, clog2 helper.
package mem_access_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_t;

  localparam int unsigned STATS_W = 16;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

endpackage

// File: rtl/mem_access_arbiter_rr_pick.sv
// Combinational round-robin pick: first set req bit scanning ptr, ptr+1, ... modulo N_REQ.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDXW  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDXW-1:0]  ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [IDXW-1:0]  idx,
  output logic             any
);

  logic [IDXW-1:0] cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = IDXW'((32'(ptr) + k) % N_REQ);
      if (!any && req[cand]) begin
        any          = 1'b1;
        idx          = cand;
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one registered-read memory among N_REQ clients.
// Optional MEM_ARB_STATS_EN adds saturating per-requester grant counters and a stall counter.
module mem_access_arbiter
  import mem_access_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned MAX_BURST = 4,
  localparam int unsigned ADDR     = clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        req_we,
  input  logic [N_REQ*ADDR-1:0]   req_addr,
  input  logic [N_REQ*WIDTH-1:0]  req_wdata,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [WIDTH-1:0]        rsp_data,
  output logic                    mem_write_en,
  output logic [ADDR-1:0]         mem_write_addr,
  output logic [WIDTH-1:0]        mem_write_data,
  output logic [ADDR-1:0]         mem_read_addr,
  input  logic [WIDTH-1:0]        mem_read_data
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [N_REQ*STATS_W-1:0] gnt_count,
  output logic [STATS_W-1:0]       stall_count
`endif
);

  localparam int unsigned IDXW = clog2(N_REQ);
  localparam int unsigned CNTW = clog2(MAX_BURST + 1);

  typedef logic [IDXW-1:0] idx_t;

  arb_state_t       state, state_nx;
  idx_t             rr_ptr, rr_ptr_nx;
  idx_t             owner, owner_nx, owner_inc;
  idx_t             pick_ptr, pick_idx, win;
  logic [CNTW-1:0]  burst_cnt, burst_cnt_nx;
  logic [N_REQ-1:0] pick_oh, gnt_int, rsp_q;
  logic             pick_any, grant, issue, rd_issue;
  logic [ADDR-1:0]  win_addr, raddr_q;

  assign owner_inc = (owner == idx_t'(N_REQ - 1)) ? '0 : owner + idx_t'(1);
  // On release the next winner is picked in the same cycle, starting just past the owner.
  assign pick_ptr  = (state == ST_OWN) ? owner_inc : rr_ptr;

  rr_pick #(
    .N_REQ(N_REQ),
    .IDXW (IDXW)
  ) u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .onehot(pick_oh),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    state_nx     = state;
    rr_ptr_nx    = rr_ptr;
    owner_nx     = owner;
    burst_cnt_nx = burst_cnt;
    grant        = 1'b0;
    win          = owner;
    gnt_int      = '0;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          state_nx     = ST_OWN;
          owner_nx     = pick_idx;
          burst_cnt_nx = CNTW'(1);
          grant        = 1'b1;
          win          = pick_idx;
          gnt_int      = pick_oh;
        end
      end
      ST_OWN: begin
        if (req[owner] && (burst_cnt < CNTW'(MAX_BURST))) begin
          grant          = 1'b1;
          gnt_int[owner] = 1'b1;
          burst_cnt_nx   = burst_cnt + CNTW'(1);
        end else begin
          rr_ptr_nx = owner_inc;
          if (pick_any) begin
            owner_nx     = pick_idx;
            burst_cnt_nx = CNTW'(1);
            grant        = 1'b1;
            win          = pick_idx;
            gnt_int      = pick_oh;
          end else begin
            state_nx     = ST_IDLE;
            burst_cnt_nx = '0;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign issue          = grant && !rst;
  assign rd_issue       = issue && !req_we[win];
  assign win_addr       = req_addr[win*ADDR +: ADDR];
  assign gnt            = rst ? '0 : gnt_int;
  assign mem_write_en   = issue && req_we[win];
  assign mem_write_addr = win_addr;
  assign mem_write_data = req_wdata[win*WIDTH +: WIDTH];
  assign mem_read_addr  = rd_issue ? win_addr : raddr_q;
  // Gated so a response registered just before reset never shows during the reset cycle.
  assign rsp_valid      = rst ? '0 : rsp_q;
  assign rsp_data       = mem_read_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
      rsp_q     <= '0;
      raddr_q   <= '0;
    end else begin
      state     <= state_nx;
      rr_ptr    <= rr_ptr_nx;
      owner     <= owner_nx;
      burst_cnt <= burst_cnt_nx;
      rsp_q     <= rd_issue ? gnt_int : '0;
      if (rd_issue) raddr_q <= win_addr;
    end
  end

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_count   <= '0;
      stall_count <= '0;
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (gnt_int[i] && (gnt_count[i*STATS_W +: STATS_W] != '1))
          gnt_count[i*STATS_W +: STATS_W] <= gnt_count[i*STATS_W +: STATS_W] + STATS_W'(1);
      end
      if ((|(req & ~gnt_int)) && (stall_count != '1))
        stall_count <= stall_count + STATS_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench for mem_access_arbiter: directed grant sequences plus a read-response scoreboard.
module tb_mem_access_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned D  = 16;
  localparam int unsigned AW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*W-1:0]  req_wdata;
  logic [N-1:0]    gnt, rsp_valid;
  logic [W-1:0]    rsp_data;
  logic            mem_write_en;
  logic [AW-1:0]   mem_write_addr, mem_read_addr;
  logic [W-1:0]    mem_write_data, mem_read_data;
`ifdef MEM_ARB_STATS_EN
  logic [N*16-1:0] gnt_count;
  logic [15:0]     stall_count;
`endif

  always #5 clk = ~clk;

  mem_access_arbiter #(
    .N_REQ    (N),
    .WIDTH    (W),
    .DEPTH    (D),
    .MAX_BURST(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .gnt           (gnt),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .mem_write_en  (mem_write_en),
    .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data),
    .mem_read_addr (mem_read_addr),
    .mem_read_data (mem_read_data)
`ifdef MEM_ARB_STATS_EN
    ,
    .gnt_count     (gnt_count),
    .stall_count   (stall_count)
`endif
  );

  logic [W-1:0] mem    [D];
  logic [W-1:0] shadow [D];

  always @(posedge clk) begin
    if (mem_write_en) mem[mem_write_addr] <= mem_write_data;
    mem_read_data <= mem[mem_read_addr];
  end

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int unsigned  idx;
    logic [W-1:0] data;
  } rsp_t;

  rsp_t sb[$];

  // Scoreboard: each observed read grant queues the response due exactly one cycle later.
  always @(negedge clk) begin
    rsp_t         e;
    logic [AW-1:0] a;
    logic [W-1:0]  d;
    if (rst) begin
      sb.delete();
      check_eq("rst_rsp_valid", 32'(rsp_valid), 32'(0));
      check_eq("rst_gnt", 32'(gnt), 32'(0));
      check_eq("rst_mem_we", 32'(mem_write_en), 32'(0));
    end else begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_eq("rsp_valid", 32'(rsp_valid), 32'(1) << e.idx);
        check_eq("rsp_data", 32'(rsp_data), 32'(e.data));
      end else begin
        check_eq("rsp_idle", 32'(rsp_valid), 32'(0));
      end
      check_eq("gnt_onehot0", 32'($onehot0(gnt)), 32'(1));
      if (gnt == '0) check_eq("idle_mem_we", 32'(mem_write_en), 32'(0));
      for (int i = 0; i < int'(N); i++) begin
        if (gnt[i]) begin
          a = req_addr[i*AW +: AW];
          d = req_wdata[i*W +: W];
          if (req_we[i]) begin
            check_eq("wr_en", 32'(mem_write_en), 32'(1));
            check_eq("wr_addr", 32'(mem_write_addr), 32'(a));
            check_eq("wr_data", 32'(mem_write_data), 32'(d));
            shadow[a] = d;
          end else begin
            check_eq("rd_mem_we", 32'(mem_write_en), 32'(0));
            check_eq("rd_addr", 32'(mem_read_addr), 32'(a));
            e.idx  = i;
            e.data = shadow[a];
            sb.push_back(e);
          end
        end
      end
    end
  end

  task automatic drive(input int unsigned i, input logic we, input logic [AW-1:0] a,
                       input logic [W-1:0] d);
    req[i]              = 1'b1;
    req_we[i]           = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*W +: W]  = d;
  endtask

  task automatic step(input string tag, input logic [N-1:0] exp_gnt);
    @(negedge clk);
    check_eq(tag, 32'(gnt), 32'(exp_gnt));
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0] d_seq [9];

  initial begin
    rst       = 1'b1;
    req       = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < int'(D); i++) begin
      mem[i]    = W'(i * 19);
      shadow[i] = W'(i * 19);
    end
    mem[5]    = 8'hA5;
    shadow[5] = 8'hA5;

    repeat (2) step("reset_gnt", 4'b0000);
    rst = 1'b0;
    step("idle_gnt", 4'b0000);

    // single read from requester 2
    drive(2, 1'b0, 4'd5, 8'h00);
    step("a_gnt", 4'b0100);
    req = '0;
    @(negedge clk);
    check_eq("a_rsp_valid", 32'(rsp_valid), 32'(4'b0100));
    check_eq("a_rsp_data", 32'(rsp_data), 32'(8'hA5));
    check_eq("a_raddr_hold", 32'(mem_read_addr), 32'(5));
    check_eq("a_gnt_idle", 32'(gnt), 32'(0));
    @(posedge clk);
    #1;

    // all four requesters held: bursts of four, no gap between owners
    rst = 1'b1;
    step("b_rst", 4'b0000);
    rst = 1'b0;
    for (int unsigned i = 0; i < N; i++) drive(i, 1'b0, AW'(i + 8), 8'h00);
    for (int c = 0; c < 20; c++) step($sformatf("b_gnt%0d", c), 4'(1 << ((c / 4) % 4)));
    req = '0;
    step("b_drop", 4'b0000);

    // write then read back the same address
    drive(1, 1'b1, 4'd7, 8'h3C);
    step("c_wr_gnt", 4'b0010);
    req_we[1] = 1'b0;
    step("c_rd_gnt", 4'b0010);
    req = '0;
    @(negedge clk);
    check_eq("c_rsp_valid", 32'(rsp_valid), 32'(4'b0010));
    check_eq("c_rsp_data", 32'(rsp_data), 32'(8'h3C));
    @(posedge clk);
    #1;

    // pointer wrap: owner 3 finishes its burst, requester 0 is next
    d_seq = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b1000};
    drive(3, 1'b0, 4'd2, 8'h00);
    drive(0, 1'b0, 4'd3, 8'h00);
    for (int c = 0; c < 9; c++) step($sformatf("d_gnt%0d", c), d_seq[c]);
    req = '0;
    step("d_drop", 4'b0000);

    // owner withdraws mid-burst: hand-off in the same cycle
    drive(1, 1'b0, 4'd4, 8'h00);
    drive(2, 1'b0, 4'd6, 8'h00);
    step("e_first", 4'b0010);
    req[1] = 1'b0;
    step("e_handoff", 4'b0100);
    req = '0;
    step("e_drop", 4'b0000);

    // reset right after a read grant: no response, pointer back to 0
    drive(1, 1'b0, 4'd9, 8'h00);
    step("g_rd", 4'b0010);
    rst = 1'b1;
    req = '0;
    drive(0, 1'b0, 4'd10, 8'h00);
    drive(3, 1'b0, 4'd11, 8'h00);
    step("g_rst", 4'b0000);
    rst = 1'b0;
    step("g_after", 4'b0001);
    req = '0;
    step("g_drop", 4'b0000);

`ifdef MEM_ARB_STATS_EN
    rst = 1'b1;
    step("s_rst", 4'b0000);
    rst = 1'b0;
    drive(3, 1'b0, 4'd1, 8'h00);
    step("s_gnt0", 4'b1000);
    drive(0, 1'b0, 4'd2, 8'h00);
    for (int c = 1; c < 4; c++) step($sformatf("s_gnt%0d", c), 4'b1000);
    req[3] = 1'b0;
    step("s_gnt4", 4'b0001);
    step("s_gnt5", 4'b0001);
    req = '0;
    @(negedge clk);
    check_eq("s_stall_count", 32'(stall_count), 32'(3));
    check_eq("s_gnt_count0", 32'(gnt_count[15:0]), 32'(2));
    check_eq("s_gnt_count3", 32'(gnt_count[63:48]), 32'(4));
    @(posedge clk);
    #1;
`endif

    step("final_idle", 4'b0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
